// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory-port arbiter: owner IDs, transfer sizes
// and arbitration FSM states.
package mem_bus_pkg;

   typedef logic owner_t;

   localparam owner_t OWN_INST = 1'b0;
   localparam owner_t OWN_DATA = 1'b1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOCK_INST = 2'd1,
      LOCK_DATA = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the arbiter: fetch side, data side, shared memory port
// and the sticky protocol-error flag.
interface mem_port_arbiter_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   logic        proto_err;

   // Arbiter view: serves both requesters and drives the shared port.
   modport master (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata,
      output proto_err
   );

   // Environment view: requesters and the memory behind the shared port.
   modport slave (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata,
      input  proto_err
   );

endinterface

// File: rtl/mem_port_arbiter_owner_fifo.sv
// In-order owner FIFO: remembers which requester issued each accepted
// request so responses can be steered back in issue order.
module owner_fifo
   import mem_bus_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  owner_t           din,
   input  logic             pop,
   output owner_t           head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   owner_t           mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters: data priority
// with a starvation guard, grant lock while stalled, in-order response steering.
module mem_port_arbiter
   import mem_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic         clk,
   input  logic         resetn,
   mem_port_arbiter_if.master bus
);

   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   arb_state_e       state;
   arb_state_e       state_nxt;
   logic             sel_vld;
   owner_t           sel_own;
   logic             sel_inst;
   logic             accept;
   logic             starved;
   logic [SC_W-1:0]  starve_cnt;
   logic             proto_err_q;

   logic             fifo_pop;
   owner_t           fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      sel_vld   = 1'b0;
      sel_own   = OWN_DATA;
      case (state)
         IDLE: begin
            // Fullness comes from the registered count, so a same-cycle pop
            // never unblocks a new request.
            if (!fifo_full) begin
               if (starved && bus.inst_req) begin
                  sel_vld = 1'b1;
                  sel_own = OWN_INST;
               end else if (bus.data_req) begin
                  sel_vld = 1'b1;
                  sel_own = OWN_DATA;
               end else if (bus.inst_req) begin
                  sel_vld = 1'b1;
                  sel_own = OWN_INST;
               end
            end
         end
         LOCK_INST: begin
            sel_own = OWN_INST;
            sel_vld = bus.inst_req;
         end
         LOCK_DATA: begin
            sel_own = OWN_DATA;
            sel_vld = bus.data_req;
         end
         default: begin
            sel_vld = 1'b0;
         end
      endcase
      if (!resetn) sel_vld = 1'b0;
      // A dropped request while locked falls through to IDLE with no push.
      if (sel_vld && !bus.addr_ok)
         state_nxt = (sel_own == OWN_INST) ? LOCK_INST : LOCK_DATA;
   end

   assign sel_inst = (sel_own == OWN_INST);
   assign accept   = sel_vld & bus.addr_ok;

   assign bus.req   = sel_vld;
   assign bus.wr    = sel_inst ? 1'b0    : bus.data_wr;
   assign bus.size  = sel_inst ? SZ_WORD : bus.data_size;
   assign bus.wstrb = sel_inst ? 4'h0    : bus.data_wstrb;
   assign bus.addr  = sel_inst ? bus.inst_addr : bus.data_addr;
   assign bus.wdata = bus.data_wdata;

   assign bus.inst_addr_ok = accept & sel_inst;
   assign bus.data_addr_ok = accept & ~sel_inst;

   assign fifo_pop         = bus.data_ok & ~fifo_empty;
   assign bus.inst_data_ok = fifo_pop & (fifo_head == OWN_INST);
   assign bus.data_data_ok = fifo_pop & (fifo_head == OWN_DATA);
   assign bus.inst_rdata   = bus.rdata;
   assign bus.data_rdata   = bus.rdata;
   assign bus.proto_err    = proto_err_q;

   owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept),
      .din    (sel_own),
      .pop    (fifo_pop),
      .head   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   // Counts data grants that overtook a waiting fetch; any gap in inst_req resets it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!bus.inst_req || (accept && sel_inst)) begin
         starve_cnt <= '0;
      end else if (accept && !starved) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                        proto_err_q <= 1'b0;
      else if (bus.data_ok && fifo_empty) proto_err_q <= 1'b1;
   end

   logic unused_count;
   assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based model of the arbitration rules.
module tb_mem_port_arbiter;
   import mem_bus_pkg::*;

   localparam int MAXO = 2;
   localparam int SLIM = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .MAX_OUTSTANDING (MAXO),
      .STARVE_LIMIT    (SLIM)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: outstanding owners in issue order (1 = data), the requester the
   // port is held for (0 none, 1 inst, 2 data), data grants in a row while a
   // fetch waits, and the sticky error.
   bit m_q[$];
   int m_lock   = 0;
   int m_streak = 0;
   bit m_perr   = 0;
   int g_exp    = 0;

   task automatic sample();
      int g;
      bit e_iok, e_dok;
      #1;
      if (!resetn) begin
         m_q.delete();
         m_lock   = 0;
         m_streak = 0;
         m_perr   = 0;
      end
      g = 0;
      if (resetn) begin
         if (m_lock == 1)      g = bus.inst_req ? 1 : 0;
         else if (m_lock == 2) g = bus.data_req ? 2 : 0;
         else if (m_q.size() < MAXO) begin
            if (m_streak >= SLIM && bus.inst_req) g = 1;
            else if (bus.data_req)                g = 2;
            else if (bus.inst_req)                g = 1;
         end
      end
      g_exp = g;
      check("req", 32'(bus.req), 32'(g != 0));
      if (g == 1) begin
         check("addr_inst", bus.addr, bus.inst_addr);
         check("ctl_inst", 32'({bus.wr, bus.size, bus.wstrb}), 32'({1'b0, SZ_WORD, 4'h0}));
      end
      if (g == 2) begin
         check("addr_data", bus.addr, bus.data_addr);
         check("ctl_data", 32'({bus.wr, bus.size, bus.wstrb}),
               32'({bus.data_wr, bus.data_size, bus.data_wstrb}));
         check("wdata", bus.wdata, bus.data_wdata);
      end
      check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(g == 1 && bus.addr_ok));
      check("data_addr_ok", 32'(bus.data_addr_ok), 32'(g == 2 && bus.addr_ok));
      e_iok = resetn && bus.data_ok && m_q.size() > 0 && m_q[0] == 1'b0;
      e_dok = resetn && bus.data_ok && m_q.size() > 0 && m_q[0] == 1'b1;
      check("inst_data_ok", 32'(bus.inst_data_ok), 32'(e_iok));
      check("data_data_ok", 32'(bus.data_data_ok), 32'(e_dok));
      if (e_iok) check("inst_rdata", bus.inst_rdata, bus.rdata);
      if (e_dok) check("data_rdata", bus.data_rdata, bus.rdata);
      check("proto_err", 32'(bus.proto_err), 32'(m_perr));
      // Advance the model to the state after the coming clock edge.
      if (resetn) begin
         if (bus.data_ok) begin
            if (m_q.size() == 0) m_perr = 1'b1;
            else void'(m_q.pop_front());
         end
         if (g != 0 && bus.addr_ok) m_q.push_back(g == 2);
         m_lock = (g != 0 && !bus.addr_ok) ? g : 0;
         if (!bus.inst_req || (g == 1 && bus.addr_ok)) m_streak = 0;
         else if (g == 2 && bus.addr_ok && m_streak < SLIM) m_streak++;
      end
   endtask

   task automatic advance();
      @(negedge clk);
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic idle_inputs();
      bus.inst_req   = 1'b0;
      bus.inst_addr  = 32'h0;
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_size  = SZ_WORD;
      bus.data_wstrb = 4'h0;
      bus.data_addr  = 32'h0;
      bus.data_wdata = 32'h0;
      bus.addr_ok    = 1'b0;
      bus.data_ok    = 1'b0;
      bus.rdata      = 32'h0;
   endtask

   initial begin
      string exp_grants;
      byte   gch;
      bit    i_hold, d_hold;

      // Reset: nothing presented even with a pending request.
      idle_inputs();
      bus.data_req = 1'b1;
      @(negedge clk);
      sample();
      check("rst_req", 32'(bus.req), 32'h0);
      check("rst_aok", 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'h0);
      check("rst_dok", 32'({bus.inst_data_ok, bus.data_data_ok}), 32'h0);
      advance();
      resetn = 1'b1;
      idle_inputs();
      step();

      // Single read steered back to the data side.
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h1c00_0100;
      bus.addr_ok   = 1'b1;
      step();
      bus.data_req = 1'b0;
      bus.addr_ok  = 1'b0;
      bus.data_ok  = 1'b1;
      bus.rdata    = 32'hdead_beef;
      sample();
      check("rd_data_ok", 32'(bus.data_data_ok), 32'h1);
      check("rd_rdata", bus.data_rdata, 32'hdead_beef);
      check("rd_inst_ok", 32'(bus.inst_data_ok), 32'h0);
      advance();
      idle_inputs();

      // Data priority and lock while addr_ok is held low.
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h2000_0040;
      bus.inst_addr = 32'h1fc0_0000;
      for (int i = 0; i < 3; i++) begin
         bus.inst_req = (i != 1);
         sample();
         check("lock_addr", bus.addr, 32'h2000_0040);
         advance();
      end
      bus.inst_req = 1'b1;
      bus.addr_ok  = 1'b1;
      sample();
      check("lock_data_aok", 32'(bus.data_addr_ok), 32'h1);
      advance();
      bus.data_req = 1'b0;
      sample();
      check("lock_inst_aok", 32'(bus.inst_addr_ok), 32'h1);
      advance();
      bus.inst_req = 1'b0;
      bus.addr_ok  = 1'b0;
      bus.data_ok  = 1'b1;
      step();
      step();
      idle_inputs();

      // Starvation guard with both requesters always active.
      exp_grants   = "DDDDIDDDDI";
      bus.data_req = 1'b1;
      bus.inst_req = 1'b1;
      bus.addr_ok  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.data_ok   = (i > 0);
         bus.data_addr = 32'h3000_0000 + 32'(i * 4);
         sample();
         gch = bus.inst_addr_ok ? "I" : (bus.data_addr_ok ? "D" : "-");
         check("starve_grant", 32'(gch), 32'(exp_grants[i]));
         advance();
      end
      idle_inputs();
      bus.data_ok = 1'b1;
      step();
      idle_inputs();

      // Full owner FIFO blocks new requests, even during a pop.
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h1fc0_0010;
      bus.addr_ok   = 1'b1;
      step();
      step();
      sample();
      check("full_req", 32'(bus.req), 32'h0);
      advance();
      bus.data_ok = 1'b1;
      bus.rdata   = 32'h5555_aaaa;
      sample();
      check("full_pop_req", 32'(bus.req), 32'h0);
      advance();
      bus.data_ok = 1'b0;
      sample();
      check("after_pop_req", 32'(bus.req), 32'h1);
      advance();
      bus.inst_req = 1'b0;
      bus.addr_ok  = 1'b0;
      bus.data_ok  = 1'b1;
      step();
      step();
      idle_inputs();

      // In-order response steering.
      bus.inst_req = 1'b1;
      bus.addr_ok  = 1'b1;
      step();
      bus.inst_req = 1'b0;
      bus.data_req = 1'b1;
      step();
      bus.data_req = 1'b0;
      bus.addr_ok  = 1'b0;
      bus.data_ok  = 1'b1;
      bus.rdata    = 32'h11;
      sample();
      check("ord_first_iok", 32'(bus.inst_data_ok), 32'h1);
      check("ord_first_rdata", bus.inst_rdata, 32'h11);
      check("ord_first_dok", 32'(bus.data_data_ok), 32'h0);
      advance();
      bus.rdata = 32'h22;
      sample();
      check("ord_second_dok", 32'(bus.data_data_ok), 32'h1);
      check("ord_second_rdata", bus.data_rdata, 32'h22);
      check("ord_second_iok", 32'(bus.inst_data_ok), 32'h0);
      advance();
      idle_inputs();

      // Response with nothing outstanding, then reset in the middle of a stall.
      bus.data_ok = 1'b1;
      step();
      bus.data_ok = 1'b0;
      sample();
      check("perr_set", 32'(bus.proto_err), 32'h1);
      advance();
      step();
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h4000_0000;
      step();
      sample();
      #1;
      resetn = 1'b0;
      sample();
      check("rst_async_req", 32'(bus.req), 32'h0);
      check("rst_async_perr", 32'(bus.proto_err), 32'h0);
      advance();
      step();
      resetn       = 1'b1;
      bus.data_req = 1'b0;
      bus.inst_req = 1'b1;
      bus.addr_ok  = 1'b1;
      sample();
      check("rst_idle_grant", 32'(bus.inst_addr_ok), 32'h1);
      advance();
      idle_inputs();
      bus.data_ok = 1'b1;
      step();
      idle_inputs();

      // Random traffic, requesters hold their fields until accepted.
      i_hold = 1'b0;
      d_hold = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (i_hold && $urandom_range(0, 31) == 0) i_hold = 1'b0;
         else if (!i_hold && $urandom_range(0, 99) < 50) begin
            i_hold        = 1'b1;
            bus.inst_addr = $urandom & 32'hffff_fffc;
         end
         if (d_hold && $urandom_range(0, 31) == 0) d_hold = 1'b0;
         else if (!d_hold && $urandom_range(0, 99) < 50) begin
            d_hold         = 1'b1;
            bus.data_wr    = 1'($urandom_range(0, 1));
            bus.data_size  = 2'($urandom_range(0, 2));
            bus.data_wstrb = 4'($urandom);
            bus.data_addr  = $urandom;
            bus.data_wdata = $urandom;
         end
         bus.inst_req = i_hold;
         bus.data_req = d_hold;
         bus.addr_ok  = ($urandom_range(0, 3) != 0);
         bus.data_ok  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         bus.rdata    = $urandom;
         sample();
         if (g_exp == 1 && bus.addr_ok) i_hold = 1'b0;
         if (g_exp == 2 && bus.addr_ok) d_hold = 1'b0;
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
